alu_result_serializer: RTL and testbench

- Downstream stage of the 8-bit ALU. Captures the ALU's 14-bit result plus its flag and overflow bits on a strobe.
- Buffers captured results in a small FIFO and emits each one as a 2-byte frame on an 8-bit valid/ready byte port.
- Lets a narrow consumer (pin-limited output or UART bridge) drain results without stalling the ALU.

---
 rtl/alu_result_serializer.sv | 106 ++++++++++
 tb/tb_alu_result_serializer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: buffers ALU results in a FIFO and emits each as a byte frame on a valid/ready port
// Ports: clk, rst_n (async active-low); cap_i/result_i/flag_i/overflow_i capture side;
//   byte_o/byte_valid_o/byte_ready_i/frame_start_o byte stream; full_o FIFO full; drop_cnt_o saturating drop count.
// Optional: define ALU_SER_CHECKSUM_EN for 3-byte frames ending in byte0^byte1.
`timescale 1ns/1ps
module alu_result_serializer #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_i,
  input  logic [13:0]       result_i,
  input  logic              flag_i,
  input  logic              overflow_i,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic              frame_start_o,
  output logic              full_o,
  output logic [DROP_W-1:0] drop_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef ALU_SER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO, SEND_CK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;
`endif
  logic [15:0]       r_mem [DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;
  state_t            r_state;
  logic [7:0]        r_lo;
  logic [7:0]        r_byte;
  logic              r_valid, r_fs;
  logic [DROP_W-1:0] r_drop;
  logic [15:0]       w_head;
  logic              w_hs, w_last, w_pop, w_push, w_full;
`ifdef ALU_SER_CHECKSUM_EN
  logic [7:0]        r_ck;
  assign w_last = w_hs && r_state == SEND_CK;
`else
  assign w_last = w_hs && r_state == SEND_LO;
`endif
  assign w_head = r_mem[r_rp];
  assign w_hs   = r_valid && byte_ready_i;
  assign w_full = r_cnt == CW'(DEPTH);
  // the head moves to the holding register only when idle or finishing a frame, giving gapless frames
  assign w_pop  = r_cnt != '0 && (r_state == IDLE || w_last);
  // a full FIFO still takes a capture when the head leaves in the same cycle
  assign w_push = cap_i && (!w_full || w_pop);
  assign byte_o        = r_byte;
  assign byte_valid_o  = r_valid;
  assign frame_start_o = r_fs;
  assign full_o        = w_full;
  assign drop_cnt_o    = r_drop;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {flag_i, overflow_i, result_i};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_drop  <= '0;
      r_state <= IDLE;
      r_lo    <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_fs    <= 1'b0;
`ifdef ALU_SER_CHECKSUM_EN
      r_ck    <= '0;
`endif
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (cap_i && !w_push && ~&r_drop) r_drop <= r_drop + DROP_W'(1);
      if (w_pop) begin
        r_lo    <= w_head[7:0];
        r_byte  <= w_head[15:8];
        r_valid <= 1'b1;
        r_fs    <= 1'b1;
        r_state <= SEND_HI;
`ifdef ALU_SER_CHECKSUM_EN
        r_ck    <= w_head[15:8] ^ w_head[7:0];
`endif
      end else if (w_last) begin
        r_byte  <= '0;
        r_valid <= 1'b0;
        r_fs    <= 1'b0;
        r_state <= IDLE;
      end else if (w_hs) begin
        r_fs <= 1'b0;
`ifdef ALU_SER_CHECKSUM_EN
        r_byte  <= r_state == SEND_HI ? r_lo : r_ck;
        r_state <= r_state == SEND_HI ? SEND_LO : SEND_CK;
`else
        r_byte  <= r_lo;
        r_state <= SEND_LO;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: queue-model and directed-vector checks of alu_result_serializer
`timescale 1ns/1ps
module tb_alu_result_serializer;
  localparam int DEPTH = 4;
`ifdef ALU_SER_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  logic clk = 0, rst_n = 0, cap_i = 0, flag_i = 0, overflow_i = 0, byte_ready_i = 0;
  logic [13:0] result_i = '0;
  logic [7:0] byte_o, drop_cnt_o;
  logic byte_valid_o, frame_start_o, full_o;
  int checks = 0, failures = 0;
  alu_result_serializer #(.DEPTH(DEPTH), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cap_i(cap_i), .result_i(result_i), .flag_i(flag_i),
    .overflow_i(overflow_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i), .frame_start_o(frame_start_o), .full_o(full_o),
    .drop_cnt_o(drop_cnt_o));
  always #5 clk = ~clk;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endfunction
  logic [7:0]  cur [$];
  logic [15:0] fq [$];
  logic [15:0] e;
  int drop_m = 0;
  bit hs, ld, acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur.delete();
      fq.delete();
      drop_m = 0;
    end else begin
      hs  = cur.size() > 0 && byte_ready_i;
      ld  = fq.size() > 0 && (cur.size() == 0 || (hs && cur.size() == 1));
      acc = cap_i && (fq.size() < DEPTH || ld);
      if (hs) void'(cur.pop_front());
      if (ld) begin
        e = fq.pop_front();
        cur.push_back(e[15:8]);
        cur.push_back(e[7:0]);
        if (NB == 3) cur.push_back(e[15:8] ^ e[7:0]);
      end
      if (acc) fq.push_back({flag_i, overflow_i, result_i});
      else if (cap_i && drop_m < 255) drop_m++;
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_valid", byte_valid_o, cur.size() > 0);
      if (cur.size() > 0) chk("m_byte", byte_o, cur[0]);
      chk("m_fs", frame_start_o, cur.size() == NB);
      chk("m_full", full_o, fq.size() == DEPTH);
      chk("m_drop", drop_cnt_o, drop_m);
    end
  end
  task automatic do_reset();
    @(negedge clk);
    cap_i = 0;
    byte_ready_i = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", byte_valid_o, 0);
    chk("rst_byte", byte_o, 0);
    chk("rst_fs", frame_start_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    rst_n = 1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_valid", byte_valid_o, 0);
    end
    @(negedge clk);
    result_i = 14'h2ABC; flag_i = 1; overflow_i = 0; cap_i = 1; byte_ready_i = 1;
    @(negedge clk);
    cap_i = 0;
    chk("sf_lat", byte_valid_o, 0);
    @(negedge clk);
    chk("sf_v0", byte_valid_o, 1);
    chk("sf_b0", byte_o, 8'hAA);
    chk("sf_fs0", frame_start_o, 1);
    @(negedge clk);
    chk("sf_b1", byte_o, 8'hBC);
    chk("sf_fs1", frame_start_o, 0);
    if (NB == 3) begin
      @(negedge clk);
      chk("sf_ck", byte_o, 8'h16);
    end
    @(negedge clk);
    chk("sf_end", byte_valid_o, 0);
    do_reset();
    @(negedge clk);
    cap_i = 1;
    @(negedge clk);
    cap_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", byte_valid_o, 1);
      chk("bp_byte", byte_o, 8'hAA);
    end
    byte_ready_i = 1;
    @(negedge clk);
    chk("bp_b1", byte_o, 8'hBC);
    repeat (NB) @(negedge clk);
    chk("bp_end", byte_valid_o, 0);
    do_reset();
    flag_i = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 6) chk("ov_full5", full_o, 1);
      cap_i = 1;
      result_i = 14'(i);
    end
    @(negedge clk);
    cap_i = 0;
    chk("ov_full", full_o, 1);
    chk("ov_drop", drop_cnt_o, 1);
    byte_ready_i = 1;
    for (int k = 0; k < 5 * NB; k++) begin
      chk("ov_valid", byte_valid_o, 1);
      chk("ov_byte", byte_o, (k % NB == 0) ? 0 : k / NB + 1);
      @(negedge clk);
    end
    chk("ov_end", byte_valid_o, 0);
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      cap_i = 1;
      result_i = 14'(i + 16);
    end
    @(negedge clk);
    cap_i = 0;
    chk("fp_full0", full_o, 1);
    byte_ready_i = 1;
    repeat (NB - 1) @(negedge clk);
    cap_i = 1; result_i = 14'h3FFF; flag_i = 1; overflow_i = 1;
    @(negedge clk);
    cap_i = 0;
    chk("fp_full", full_o, 1);
    chk("fp_drop", drop_cnt_o, 0);
    repeat (6 * NB + 2) @(negedge clk);
    chk("fp_end", byte_valid_o, 0);
    do_reset();
    flag_i = 0; overflow_i = 0;
    @(negedge clk);
    cap_i = 1; result_i = 14'h1234; byte_ready_i = 1;
    @(negedge clk);
    cap_i = 0;
    @(negedge clk);
    chk("rm_b0", byte_o, 8'h12);
    @(negedge clk);
    chk("rm_b1", byte_o, 8'h34);
    byte_ready_i = 0;
    #2 rst_n = 0;
    #1 chk("rm_async", byte_valid_o, 0);
    @(negedge clk);
    rst_n = 1;
    byte_ready_i = 1;
    repeat (10) begin
      @(negedge clk);
      chk("rm_quiet", byte_valid_o, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
